// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream and writes it into
// instruction memory one 32-bit word at a time, holding the CPU in reset until the image verifies.
module imem_loader #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [31:0]   imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [AW:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(2 ** AW);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] asm_q, asm_d;
  logic [7:0]  csum_q, csum_d;
  logic [AW:0] wc_q, wc_d;
  logic        we_q, we_d;
  logic        last_q, last_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        xfer;
  logic [15:0] len_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      lane_q  <= '0;
      asm_q   <= '0;
      csum_q  <= '0;
      wc_q    <= '0;
      we_q    <= 1'b0;
      last_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      csum_q  <= csum_d;
      wc_q    <= wc_d;
      we_q    <= we_d;
      last_q  <= last_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    lane_d   = lane_q;
    asm_d    = asm_q;
    csum_d   = csum_q;
    wc_d     = wc_q;
    we_d     = 1'b0;
    last_d   = last_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    len_full = {len_q[15:8], byte_data};

    byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                 (state_q == S_DATA)   || (state_q == S_CSUM);
    xfer = byte_valid && byte_ready;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          wc_d    = '0;
          csum_d  = '0;
          lane_d  = '0;
          last_d  = 1'b0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = byte_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_full;
          if ({1'b0, len_full} > MAX_WORDS) state_d = S_ERR;
          else if (len_full == 16'd0)       state_d = S_CSUM;
          else                              state_d = S_DATA;
        end
      end
      S_DATA: begin
        // The write cycle of the final word doubles as the checksum slot, so the stream never stalls.
        if (we_q && last_q) begin
          if (xfer) state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
          else      state_d = S_CSUM;
        end else if (xfer) begin
          asm_d  = {asm_q[23:0], byte_data};
          csum_d = csum_q ^ byte_data;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {asm_q[23:0], byte_data};
            waddr_d = 32'(wc_q) << 2;
            wc_d    = wc_q + 1'b1;
            last_d  = ((16'(wc_q) + 16'd1) == len_q);
          end
        end
      end
      S_CSUM: begin
        if (xfer) state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gate with reset so a write scheduled for the reset cycle never reaches memory.
  assign imem_we    = we_q && !reset;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized image loads checked against a stream-level model of the loader.
module tb_imem_loader;

  localparam int AW = 6;
  localparam int MAXW = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset, start, byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready, imem_we, cpu_hold, done, error;
  logic [31:0]   imem_waddr, imem_wdata;
  logic [AW:0]   word_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] ld_words [0:MAXW-1];
  logic [63:0] cap_q [$];

  imem_loader #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Record every write strobe seen at the clock edge where memory would capture it.
  always @(posedge clk) begin
    if (imem_we === 1'b1) cap_q.push_back({imem_waddr, imem_wdata});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL byte_ready timeout observed=0 expected=1");
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // Build the stream from the format rules, send it, then compare writes and final status.
  task automatic run_load(input string tag, input int n, input logic [7:0] cmask,
                          input int gap, input int start_mid);
    logic [7:0] stream [$];
    logic [7:0] cs = 8'h00;
    bit oversize = (n > MAXW);
    int exp_n;
    bit exp_ok;
    logic [31:0] w;
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    if (!oversize) begin
      for (int i = 0; i < n; i++) begin
        for (int k = 3; k >= 0; k--) begin
          w = ld_words[i] >> (8 * k);
          stream.push_back(w[7:0]);
          cs = cs ^ w[7:0];
        end
      end
      stream.push_back(cs ^ cmask);
    end
    exp_n  = oversize ? 0 : n;
    exp_ok = !oversize && (cmask == 8'h00);

    cap_q.delete();
    pulse_start();
    for (int i = 0; i < stream.size(); i++) begin
      if (i == start_mid) pulse_start();
      send_byte(stream[i]);
      if (oversize && i == 1) begin
        chk({tag, " oversize error"}, 32'(error), 32'd1);
        chk({tag, " oversize ready"}, 32'(byte_ready), 32'd0);
        break;
      end
      repeat (gap) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    chk({tag, " nwrites"}, 32'(cap_q.size()), 32'(exp_n));
    for (int j = 0; j < exp_n && j < cap_q.size(); j++) begin
      chk($sformatf("%s waddr[%0d]", tag, j), cap_q[j][63:32], 32'(j * 4));
      chk($sformatf("%s wdata[%0d]", tag, j), cap_q[j][31:0], ld_words[j]);
    end
    chk({tag, " done"},       32'(done),       32'(exp_ok));
    chk({tag, " error"},      32'(error),      32'(!exp_ok));
    chk({tag, " cpu_hold"},   32'(cpu_hold),   32'(!exp_ok));
    chk({tag, " word_count"}, 32'(word_count), 32'(exp_n));
    chk({tag, " byte_ready"}, 32'(byte_ready), 32'd0);
    $display("load %s: n=%0d cmask=%h gap=%0d writes=%0d done=%0b error=%0b",
             tag, n, cmask, gap, cap_q.size(), done, error);
  endtask

  task automatic set_normal();
    ld_words[0] = 32'h0800001D;
    ld_words[1] = 32'h00000000;
  endtask

  initial begin
    logic [7:0] normal_prefix [0:5];
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst byte_ready", 32'(byte_ready), 32'd0);
    chk("rst imem_we",    32'(imem_we),    32'd0);
    chk("rst waddr",      imem_waddr,      32'd0);
    chk("rst wdata",      imem_wdata,      32'd0);
    chk("rst cpu_hold",   32'(cpu_hold),   32'd1);
    chk("rst done",       32'(done),       32'd0);
    chk("rst error",      32'(error),      32'd0);
    chk("rst word_count", 32'(word_count), 32'd0);

    set_normal();
    run_load("normal",   2,  8'h00, 0, -1);
    run_load("badcsum",  2,  8'h01, 0, -1);
    run_load("oversize", 65, 8'h00, 0, -1);
    run_load("empty",    0,  8'h00, 0, -1);
    run_load("emptybad", 0,  8'h01, 0, -1);
    run_load("gaps",     2,  8'h00, 3, -1);
    run_load("startmid", 2,  8'h00, 1, 5);

    // Reset during the write cycle of the first word: that write must not appear.
    normal_prefix = '{8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h1D};
    cap_q.delete();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(normal_prefix[i]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst nwrites",    32'(cap_q.size()), 32'd0);
    chk("midrst cpu_hold",   32'(cpu_hold),     32'd1);
    chk("midrst byte_ready", 32'(byte_ready),   32'd0);
    chk("midrst done",       32'(done),         32'd0);
    chk("midrst word_count", 32'(word_count),   32'd0);
    $display("midrst: writes=%0d cpu_hold=%0b", cap_q.size(), cpu_hold);
    run_load("reload", 2, 8'h00, 0, -1);

    for (int i = 0; i < MAXW; i++) ld_words[i] = $urandom;
    run_load("full64",  64,  8'h00, 0, -1);
    run_load("len256",  256, 8'h00, 0, -1);

    for (int t = 0; t < 8; t++) begin
      int n = $urandom_range(0, 8);
      logic [7:0] cm = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      for (int i = 0; i < n; i++) ld_words[i] = $urandom;
      run_load($sformatf("rand%0d", t), n, cm, $urandom_range(0, 2), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
